// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the single-clock FIFO over a registered-read memory.
// Owns the read pointer and hides the one-cycle read latency behind a 2-entry output stage.
module fifo_rd_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rreset,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rclken,
    input  logic [DATASIZE-1:0] rdata,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} stage_e;

    stage_e              state;
    logic [DATASIZE-1:0] skid;
    logic                inflight;
    logic                mem_empty;
    logic                pop;
    logic [2:0]          scnt;

    assign scnt      = {1'b0, state};
    assign mem_empty = (wptr == rptr);
    assign pop       = m_valid & m_ready;
    assign raddr     = rptr[ADDRSIZE-1:0];
    assign rlevel    = wptr - rptr;
    assign rempty    = mem_empty & ~inflight & (state == EMPTY);

    // Never commit more reads than the stage can hold once this cycle's pop leaves.
    assign rclken = rreset & ~mem_empty & ((scnt + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    always_ff @(posedge rclk) begin
        if (!rreset) begin
            rptr     <= '0;
            inflight <= 1'b0;
            state    <= EMPTY;
            m_data   <= '0;
            m_valid  <= 1'b0;
            skid     <= '0;
        end else begin
            inflight <= rclken;
            if (rclken)
                rptr <= rptr + 1'b1;
            // Returning read data always lands at the tail; head only changes on pop.
            case (state)
                EMPTY: begin
                    if (inflight) begin
                        m_data  <= rdata;
                        m_valid <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (inflight && pop) begin
                        m_data <= rdata;
                    end else if (inflight) begin
                        skid  <= rdata;
                        state <= TWO;
                    end else if (pop) begin
                        m_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        m_data <= skid;
                        state  <= ONE;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural registered-read memory, table of preload vectors,
// scoreboard-checked streams and hand-written latency / reset sequences.
module tb_fifo_rd_ctrl;

    localparam int DS = 8;
    localparam int AS = 4;

    logic          rclk;
    logic          rreset;
    logic [AS:0]   wptr;
    logic [AS:0]   rptr;
    logic [AS-1:0] raddr;
    logic          rclken;
    logic [DS-1:0] rdata;
    logic [DS-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          rempty;
    logic [AS:0]   rlevel;

    fifo_rd_ctrl #(.DATASIZE(DS), .ADDRSIZE(AS)) dut (
        .rclk(rclk), .rreset(rreset), .wptr(wptr), .rptr(rptr), .raddr(raddr),
        .rclken(rclken), .rdata(rdata), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .rempty(rempty), .rlevel(rlevel)
    );

    logic [DS-1:0] mem [16];
    always @(posedge rclk) if (rclken) rdata <= mem[raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_popped = 0;
    logic [DS-1:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word must be the oldest one written.
    always @(negedge rclk) begin
        if (rreset && m_valid && m_ready) begin
            if (q.size() == 0) chk("sb_unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
            else chk("sb_data", 32'(m_data), 32'(q.pop_front()));
            n_popped++;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge rclk);
        #1;
        rreset  = 1'b0;
        wptr    = '0;
        m_ready = 1'b0;
        q.delete();
        repeat (2) @(posedge rclk);
        #1;
        rreset = 1'b1;
    endtask

    task automatic write_words(input int n, input logic [DS-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wptr[AS-1:0]] = base + DS'(i);
            q.push_back(base + DS'(i));
            wptr = wptr + 1'b1;
        end
    endtask

    typedef struct {
        int            n;
        logic [AS:0]   exp_rptr;
        logic [AS:0]   exp_level;
        logic          exp_valid;
        logic          exp_empty;
        logic [DS-1:0] exp_data;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first, last, nv, pulses, base;
        logic saw_wrap, over;
        logic [AS:0] prev_rptr, lvl;
        int wr;

        rreset = 1'b0; wptr = '0; m_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset held for 3 cycles with an empty writer
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        chk("rst_rptr", 32'(rptr), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_rclken", 32'(rclken), 0);
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_rlevel", 32'(rlevel), 0);

        // Preload n words under full backpressure: at most two reads may complete
        tbl[0] = '{0,  5'd0, 5'd0,  1'b0, 1'b1, 8'h00};
        tbl[1] = '{1,  5'd1, 5'd0,  1'b1, 1'b0, 8'h40};
        tbl[2] = '{2,  5'd2, 5'd0,  1'b1, 1'b0, 8'h40};
        tbl[3] = '{3,  5'd2, 5'd1,  1'b1, 1'b0, 8'h40};
        tbl[4] = '{16, 5'd2, 5'd14, 1'b1, 1'b0, 8'h40};
        for (int t = 0; t < 5; t++) begin
            do_reset();
            write_words(tbl[t].n, 8'h40);
            repeat (5) tick();
            @(negedge rclk);
            chk($sformatf("tbl%0d_rptr", t), 32'(rptr), 32'(tbl[t].exp_rptr));
            chk($sformatf("tbl%0d_rlevel", t), 32'(rlevel), 32'(tbl[t].exp_level));
            chk($sformatf("tbl%0d_m_valid", t), 32'(m_valid), 32'(tbl[t].exp_valid));
            chk($sformatf("tbl%0d_rempty", t), 32'(rempty), 32'(tbl[t].exp_empty));
            chk($sformatf("tbl%0d_m_data", t), 32'(m_data), 32'(tbl[t].exp_data));
            chk($sformatf("tbl%0d_rclken", t), 32'(rclken), 0);
        end

        // Single word: issue in the write cycle, visible two edges later, drained after the third
        do_reset();
        m_ready = 1'b1;
        tick();
        write_words(1, 8'hA5);
        @(negedge rclk);
        chk("single_rclken_e0", 32'(rclken), 1);
        chk("single_m_valid_e0", 32'(m_valid), 0);
        chk("single_rempty_e0", 32'(rempty), 0);
        @(negedge rclk);
        chk("single_m_valid_e1", 32'(m_valid), 0);
        chk("single_rclken_e1", 32'(rclken), 0);
        chk("single_rempty_e1", 32'(rempty), 0);
        @(negedge rclk);
        chk("single_m_valid_e2", 32'(m_valid), 1);
        chk("single_m_data_e2", 32'(m_data), 32'hA5);
        @(negedge rclk);
        chk("single_rempty_e3", 32'(rempty), 1);
        chk("single_m_valid_e3", 32'(m_valid), 0);

        // Burst: full memory drains with no bubbles
        do_reset();
        m_ready = 1'b1;
        write_words(16, 8'h00);
        @(negedge rclk);
        chk("burst_rlevel", 32'(rlevel), 16);
        first = -1; last = -1; nv = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge rclk);
            if (m_valid) begin
                if (first < 0) first = c;
                last = c;
                nv++;
            end
        end
        chk("burst_valid_cycles", 32'(nv), 16);
        chk("burst_contiguous", 32'(last - first + 1), 16);
        chk("burst_rptr", 32'(rptr), 16);
        chk("burst_rempty", 32'(rempty), 1);
        chk("burst_sb_drained", 32'(q.size()), 0);

        // Backpressure: two reads, then stall; release restarts reads in the same cycle
        do_reset();
        write_words(8, 8'h80);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge rclk);
            if (rclken) pulses++;
        end
        chk("bp_rclken_pulses", 32'(pulses), 2);
        chk("bp_m_data_held", 32'(m_data), 32'h80);
        chk("bp_m_valid", 32'(m_valid), 1);
        chk("bp_rlevel", 32'(rlevel), 6);
        tick();
        m_ready = 1'b1;
        @(negedge rclk);
        chk("bp_release_rclken", 32'(rclken), 1);
        first = -1; last = -1; nv = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge rclk);
            if (m_valid) begin
                if (first < 0) first = c;
                last = c;
                nv++;
            end
        end
        chk("bp_valid_cycles", 32'(nv), 8);
        chk("bp_contiguous", 32'(last - first + 1), 8);
        chk("bp_sb_drained", 32'(q.size()), 0);

        // Wrap-around: 40 words through a 16-deep memory, random consumer
        do_reset();
        base = n_popped; wr = 0; saw_wrap = 1'b0; over = 1'b0; prev_rptr = '0;
        for (int c = 0; c < 2000 && (n_popped - base) < 40; c++) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
            lvl = wptr - rptr;
            if (wr < 40 && lvl < 5'd16 && $urandom_range(0, 3) != 0) begin
                write_words(1, DS'(wr * 7 + 3));
                wr++;
            end
            @(negedge rclk);
            if (rlevel > 5'd16) over = 1'b1;
            if (prev_rptr == 5'd31 && rptr == 5'd0) saw_wrap = 1'b1;
            prev_rptr = rptr;
        end
        tick();
        m_ready = 1'b0;
        chk("wrap_words_received", 32'(n_popped - base), 40);
        chk("wrap_rptr_wrapped", 32'(saw_wrap), 1);
        chk("wrap_final_rptr", 32'(rptr), 8);
        chk("wrap_level_bound", 32'(over), 0);
        chk("wrap_sb_drained", 32'(q.size()), 0);

        // Mid-stream reset with a full output stage, then fresh data at normal latency
        do_reset();
        write_words(4, 8'h10);
        repeat (4) tick();
        @(negedge rclk);
        chk("mrst_pre_rptr", 32'(rptr), 2);
        chk("mrst_pre_m_valid", 32'(m_valid), 1);
        tick();
        rreset = 1'b0;
        wptr   = '0;
        q.delete();
        @(negedge rclk);
        chk("mrst_rclken_low", 32'(rclken), 0);
        @(negedge rclk);
        chk("mrst_m_valid", 32'(m_valid), 0);
        chk("mrst_rptr", 32'(rptr), 0);
        chk("mrst_m_data", 32'(m_data), 0);
        chk("mrst_rempty", 32'(rempty), 1);
        tick();
        rreset  = 1'b1;
        m_ready = 1'b1;
        tick();
        write_words(1, 8'h3C);
        @(negedge rclk);
        chk("mrst_fresh_rclken", 32'(rclken), 1);
        @(negedge rclk);
        chk("mrst_fresh_m_valid_e1", 32'(m_valid), 0);
        @(negedge rclk);
        chk("mrst_fresh_m_valid_e2", 32'(m_valid), 1);
        chk("mrst_fresh_m_data", 32'(m_data), 32'h3C);
        @(negedge rclk);
        chk("mrst_fresh_rempty", 32'(rempty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
